// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the MIPS pipeline-stage registers.
//   PC_RESET_DEFAULT : PC value presented by a stage after reset.
//   WDSEL_*          : 4-bit write-data select encodings carried with each
//                      instruction down to the W stage.
//   pipe_ctl_t       : control bundle {pc, regwrite, a3, wdsel} registered by
//                      every stage instance.
//   ctl_from_inputs  : builds a pipe_ctl_t, masking any GRF write to $0.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [3:0] WDSEL_ALU = 4'd0;
  localparam logic [3:0] WDSEL_MEM = 4'd1;
  localparam logic [3:0] WDSEL_PC8 = 4'd2;
  localparam logic [3:0] WDSEL_HI  = 4'd3;
  localparam logic [3:0] WDSEL_LO  = 4'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        regwrite;
    logic [4:0]  a3;
    logic [3:0]  wdsel;
  } pipe_ctl_t;

  // $0 is hard-wired to zero, so a write to it is dropped at the register.
  function automatic pipe_ctl_t ctl_from_inputs(input logic [31:0] pc,
                                                input logic        regwrite,
                                                input logic [4:0]  a3,
                                                input logic [3:0]  wdsel);
    pipe_ctl_t c;
    c.pc       = pc;
    c.regwrite = regwrite && (a3 != 5'd0);
    c.a3       = a3;
    c.wdsel    = wdsel;
    return c;
  endfunction

  // True for the write-data selects defined by the core.
  function automatic logic wdsel_known(input logic [3:0] w);
    return (w == WDSEL_ALU) || (w == WDSEL_MEM) || (w == WDSEL_PC8) ||
           (w == WDSEL_HI)  || (w == WDSEL_LO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : synchronous, active-high, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   cnt   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline-stage register for the E/M/W
// boundaries of the five-stage MIPS core.
//
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer; in_ready
// then comes straight from a flop and has no combinational path from
// out_ready. Without it, in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   in_pc, in_regwrite, in_a3,
//   in_wdsel, in_data           incoming instruction fields
//   flush                       kill held and incoming instruction
//   out_valid / out_ready       downstream handshake
//   out_pc, out_regwrite,
//   out_a3, out_wdsel, out_data registered instruction fields
//   stall_cnt                   saturating count of out_valid && !out_ready
//   bubble_cnt                  saturating count of !out_valid
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_regwrite,
  input  logic [4:0]        in_a3,
  input  logic [3:0]        in_wdsel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_regwrite,
  output logic [4:0]        out_a3,
  output logic [3:0]        out_wdsel,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_ctl_t         r_out_ctl;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  pipe_ctl_t         w_in_ctl;
  logic              w_out_free;
  logic              w_xfer_in;
  logic              w_xfer_out;

  assign w_in_ctl   = ctl_from_inputs(in_pc, in_regwrite, in_a3, in_wdsel);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;

`ifdef PIPE_SKID_EN
  pipe_ctl_t         r_skid_ctl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_full;

  assign in_ready = !r_skid_full;
`else
  assign in_ready = w_out_free;
`endif

  // Stage boundary: input -> output register (plus skid entry when enabled).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid        <= 1'b0;
      r_out_ctl.pc       <= PC_RESET;
      r_out_ctl.regwrite <= 1'b0;
      r_out_ctl.a3       <= 5'd0;
      r_out_ctl.wdsel    <= WDSEL_ALU;
      r_out_data         <= '0;
`ifdef PIPE_SKID_EN
      r_skid_full        <= 1'b0;
`endif
    end else if (flush) begin
      // Bubble: only the qualifiers are cleared, the fields keep their values.
      r_out_valid        <= 1'b0;
      r_out_ctl.regwrite <= 1'b0;
`ifdef PIPE_SKID_EN
      r_skid_full        <= 1'b0;
`endif
    end else begin
`ifdef PIPE_SKID_EN
      if (r_skid_full) begin
        // A full skid implies a valid output; in_ready is low, so no new
        // instruction can arrive while the skid drains.
        if (out_ready) begin
          r_out_ctl   <= r_skid_ctl;
          r_out_data  <= r_skid_data;
          r_skid_full <= 1'b0;
        end
      end else if (w_xfer_in) begin
        if (w_out_free) begin
          r_out_valid <= 1'b1;
          r_out_ctl   <= w_in_ctl;
          r_out_data  <= in_data;
        end else begin
          r_skid_ctl  <= w_in_ctl;
          r_skid_data <= in_data;
          r_skid_full <= 1'b1;
        end
      end else if (w_xfer_out) begin
        r_out_valid        <= 1'b0;
        r_out_ctl.regwrite <= 1'b0;
      end
`else
      if (w_xfer_in) begin
        r_out_valid <= 1'b1;
        r_out_ctl   <= w_in_ctl;
        r_out_data  <= in_data;
      end else if (w_xfer_out) begin
        r_out_valid        <= 1'b0;
        r_out_ctl.regwrite <= 1'b0;
      end
`endif
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_ctl.pc;
  assign out_regwrite = r_out_ctl.regwrite;
  assign out_a3       = r_out_ctl.a3;
  assign out_wdsel    = r_out_ctl.wdsel;
  assign out_data     = r_out_data;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!r_out_valid),
    .cnt   (bubble_cnt)
  );

endmodule
